// File: rtl/fifo_rr_scheduler.sv
// Packet-aware round-robin drain of NUM_PORTS FWFT FIFOs into one registered valid/ready stream.
// Grant is held until an EOP pop or a MAX_PKT_LEN forced release; one IDLE cycle between packets.
module fifo_rr_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout,
  input  logic [NUM_PORTS-1:0]            fifo_eop,
  output logic [NUM_PORTS-1:0]            fifo_rd_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_eop,
  output logic [$clog2(NUM_PORTS)-1:0]    out_port,
  output logic                            busy,
  output logic                            pkt_timeout
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int CNT_W  = $clog2(MAX_PKT_LEN + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]            state;
  logic [PORT_W-1:0]     grant;
  logic [PORT_W-1:0]     last_grant;
  logic [PORT_W-1:0]     next_grant;
  logic [PORT_W-1:0]     cand;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  found;
  logic                  any_pending;
  logic                  can_load;
  logic                  pop;
  logic                  head_eop;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] head_data;

  assign can_load    = ~out_valid | out_ready;
  assign pop         = (state == XFER) & ~fifo_empty[grant] & can_load;
  assign head_data   = fifo_dout[grant*DATA_WIDTH +: DATA_WIDTH];
  assign head_eop    = fifo_eop[grant];
  assign last_beat   = (beat_cnt == CNT_W'(MAX_PKT_LEN - 1));
  assign any_pending = ~&fifo_empty;

  always_comb begin
    fifo_rd_en        = '0;
    fifo_rd_en[grant] = pop;
  end

  // Search starts just after the last served port, so the previous owner is checked last.
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && !fifo_empty[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= PORT_W'(NUM_PORTS - 1);
      beat_cnt    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_eop     <= 1'b0;
      out_port    <= '0;
      busy        <= 1'b0;
      pkt_timeout <= 1'b0;
    end else begin
      pkt_timeout <= 1'b0;
      if (pop) begin
        out_data  <= head_data;
        out_port  <= grant;
        out_valid <= 1'b1;
        out_eop   <= head_eop | last_beat;
        beat_cnt  <= beat_cnt + 1'b1;
        if (head_eop || last_beat) begin
          state       <= IDLE;
          busy        <= 1'b0;
          last_grant  <= grant;
          pkt_timeout <= ~head_eop & last_beat;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (state == IDLE && any_pending) begin
        grant    <= next_grant;
        beat_cnt <= '0;
        state    <= XFER;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: queue-backed FWFT FIFO models, outputs logged on handshake.
module tb_fifo_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  fifo_empty;
  logic [63:0] fifo_dout;
  logic [3:0]  fifo_eop;
  logic [3:0]  fifo_rd_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_eop;
  logic [1:0]  out_port;
  logic        busy;
  logic        pkt_timeout;

  logic [16:0] fq [4][$];
  logic [18:0] lg [$];
  int          lg_cyc [$];
  int          cyc;
  int          mh_err;
  int          n_cmp;
  int          n_bad;

  fifo_rr_scheduler #(.NUM_PORTS(4), .DATA_WIDTH(16), .MAX_PKT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_eop(fifo_eop), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_eop(out_eop),
    .out_port(out_port), .busy(busy), .pkt_timeout(pkt_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      if (fq[i].size() != 0) {fifo_eop[i], fifo_dout[i*16 +: 16]} = fq[i][0];
      else {fifo_eop[i], fifo_dout[i*16 +: 16]} = 17'd0;
    end
  endtask

  task automatic push(input int p, input logic [15:0] d, input logic e);
    fq[p].push_back({e, d});
    refresh();
  endtask

  // One clock: sample pops and handshakes just before the edge, apply pops just after it.
  task automatic step();
    logic [3:0] rd;
    #1;
    rd = fifo_rd_en;
    if ($countones(rd) > 1) mh_err++;
    for (int i = 0; i < 4; i++) if (rd[i] && fq[i].size() == 0) mh_err++;
    if (out_valid && out_ready) begin
      lg.push_back({out_port, out_eop, out_data});
      lg_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) if (rd[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    refresh();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_log();
    lg.delete();
    lg_cyc.delete();
    mh_err = 0;
  endtask

  task automatic check_log(input string name, input logic [18:0] exp [$]);
    logic [18:0] act;
    n_cmp++;
    if (lg.size() != exp.size()) begin
      n_bad++;
      $display("FAIL %s_count: got %0d words want %0d", name, lg.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      act = (i < lg.size()) ? lg[i] : 19'h7ffff;
      n_cmp++;
      if (act !== exp[i]) begin
        n_bad++;
        $display("FAIL %s_word%0d: got port/eop/data %h want %h", name, i, act, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    refresh();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_eop, busy, pkt_timeout} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {out_valid, out_eop, busy, pkt_timeout});
    end
    n_cmp++;
    if ({out_data, out_port, fifo_rd_en} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {out_data, out_port, fifo_rd_en});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({busy, out_valid, fifo_rd_en} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_idle: got %b want 000000", {busy, out_valid, fifo_rd_en});
    end
  endtask

  task automatic test_single();
    logic [19:0] exp_o [4];
    exp_o[0] = {1'b1, 2'd2, 1'b0, 16'hA001};
    exp_o[1] = {1'b1, 2'd2, 1'b0, 16'hB002};
    exp_o[2] = {1'b1, 2'd2, 1'b1, 16'hC003};
    exp_o[3] = {1'b0, 2'd2, 1'b1, 16'hC003};
    push(2, 16'hA001, 1'b0);
    push(2, 16'hB002, 1'b0);
    push(2, 16'hC003, 1'b1);
    step();
    n_cmp++;
    if ({busy, fifo_rd_en} !== 5'b10100) begin
      n_bad++;
      $display("FAIL single_grant: got busy/rd %b want 10100", {busy, fifo_rd_en});
    end
    for (int e = 0; e < 4; e++) begin
      step();
      n_cmp++;
      if ({out_valid, out_port, out_eop, out_data} !== exp_o[e]) begin
        n_bad++;
        $display("FAIL single_edge%0d: got %h want %h", e + 2, {out_valid, out_port, out_eop, out_data}, exp_o[e]);
      end
      if (e == 2) begin
        n_cmp++;
        if ({busy, fifo_rd_en} !== 5'b00000) begin
          n_bad++;
          $display("FAIL single_release: got busy/rd %b want 00000", {busy, fifo_rd_en});
        end
      end
    end
  endtask

  task automatic test_rr_all();
    logic [18:0] exp [$];
    reset_dut();
    clear_log();
    for (int p = 0; p < 4; p++) begin
      push(p, 16'h1000 + 16'(p * 256), 1'b0);
      push(p, 16'h1001 + 16'(p * 256), 1'b1);
      exp.push_back({2'(p), 1'b0, 16'h1000 + 16'(p * 256)});
      exp.push_back({2'(p), 1'b1, 16'h1001 + 16'(p * 256)});
    end
    repeat (14) step();
    check_log("rr", exp);
    for (int i = 0; i + 1 < lg_cyc.size(); i++) begin
      n_cmp++;
      if (lg_cyc[i+1] - lg_cyc[i] != ((i % 2 == 0) ? 1 : 2)) begin
        n_bad++;
        $display("FAIL rr_gap%0d: got %0d cycles want %0d", i, lg_cyc[i+1] - lg_cyc[i], (i % 2 == 0) ? 1 : 2);
      end
    end
    n_cmp++;
    if (mh_err != 0) begin
      n_bad++;
      $display("FAIL rr_onehot: got %0d bad rd_en cycles want 0", mh_err);
    end
  endtask

  task automatic test_back_pressure();
    logic [18:0] exp [$];
    clear_log();
    push(1, 16'h5101, 1'b0);
    push(1, 16'h5102, 1'b1);
    step();
    n_cmp++;
    if (fifo_rd_en !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_grant: got rd %b want 0010", fifo_rd_en);
    end
    step();
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({out_valid, out_port, out_eop, out_data, fifo_rd_en} !== {1'b1, 2'd1, 1'b0, 16'h5101, 4'b0000}) begin
        n_bad++;
        $display("FAIL bp_stall%0d: got %h want %h", s, {out_valid, out_port, out_eop, out_data, fifo_rd_en},
                 {1'b1, 2'd1, 1'b0, 16'h5101, 4'b0000});
      end
      if (s < 2) step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (fifo_rd_en !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_resume: got rd %b want 0010", fifo_rd_en);
    end
    step();
    n_cmp++;
    if ({out_valid, out_eop, out_data} !== {1'b1, 1'b1, 16'h5102}) begin
      n_bad++;
      $display("FAIL bp_second: got %h want %h", {out_valid, out_eop, out_data}, {1'b1, 1'b1, 16'h5102});
    end
    step();
    exp.push_back({2'd1, 1'b0, 16'h5101});
    exp.push_back({2'd1, 1'b1, 16'h5102});
    check_log("bp", exp);
  endtask

  task automatic test_timeout();
    logic [18:0] exp [$];
    clear_log();
    for (int k = 0; k < 6; k++) push(0, 16'h7000 + 16'(k), (k == 5));
    push(1, 16'h8001, 1'b1);
    repeat (4) step();
    n_cmp++;
    if ({out_eop, out_data, pkt_timeout} !== {1'b0, 16'h7002, 1'b0}) begin
      n_bad++;
      $display("FAIL to_word3: got %h want %h", {out_eop, out_data, pkt_timeout}, {1'b0, 16'h7002, 1'b0});
    end
    step();
    n_cmp++;
    if ({out_valid, out_eop, out_data, pkt_timeout, busy} !== {1'b1, 1'b1, 16'h7003, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL to_forced: got %h want %h", {out_valid, out_eop, out_data, pkt_timeout, busy},
               {1'b1, 1'b1, 16'h7003, 1'b1, 1'b0});
    end
    step();
    n_cmp++;
    if ({pkt_timeout, busy, fifo_rd_en} !== 6'b010010) begin
      n_bad++;
      $display("FAIL to_next_port: got pto/busy/rd %b want 010010", {pkt_timeout, busy, fifo_rd_en});
    end
    repeat (6) step();
    for (int k = 0; k < 4; k++) exp.push_back({2'd0, (k == 3), 16'h7000 + 16'(k)});
    exp.push_back({2'd1, 1'b1, 16'h8001});
    exp.push_back({2'd0, 1'b0, 16'h7004});
    exp.push_back({2'd0, 1'b1, 16'h7005});
    check_log("to", exp);
  endtask

  task automatic test_hold_on_empty();
    logic [18:0] exp [$];
    clear_log();
    push(3, 16'h9301, 1'b0);
    step();
    step();
    n_cmp++;
    if ({out_valid, out_port, out_data} !== {1'b1, 2'd3, 16'h9301}) begin
      n_bad++;
      $display("FAIL hold_first: got %h want %h", {out_valid, out_port, out_data}, {1'b1, 2'd3, 16'h9301});
    end
    push(0, 16'h9001, 1'b1);
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if ({busy, fifo_rd_en} !== 5'b10000) begin
        n_bad++;
        $display("FAIL hold_wait%0d: got busy/rd %b want 10000", s, {busy, fifo_rd_en});
      end
      step();
    end
    push(3, 16'h9302, 1'b1);
    #1;
    n_cmp++;
    if (fifo_rd_en !== 4'b1000) begin
      n_bad++;
      $display("FAIL hold_resume: got rd %b want 1000", fifo_rd_en);
    end
    repeat (5) step();
    exp.push_back({2'd3, 1'b0, 16'h9301});
    exp.push_back({2'd3, 1'b1, 16'h9302});
    exp.push_back({2'd0, 1'b1, 16'h9001});
    check_log("hold", exp);
  endtask

  task automatic test_reset_mid();
    push(2, 16'hE001, 1'b0);
    push(2, 16'hE002, 1'b0);
    push(2, 16'hE003, 1'b1);
    step();
    step();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 16'hE001}) begin
      n_bad++;
      $display("FAIL rmid_pre: got %h want %h", {out_valid, out_data}, {1'b1, 16'hE001});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_eop, busy, pkt_timeout, out_data, out_port, fifo_rd_en} !== 26'd0) begin
      n_bad++;
      $display("FAIL rmid_async: got %h want 0", {out_valid, out_eop, busy, pkt_timeout, out_data, out_port, fifo_rd_en});
    end
    push(0, 16'hF001, 1'b1);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (fifo_rd_en !== 4'b0001) begin
      n_bad++;
      $display("FAIL rmid_port0_first: got rd %b want 0001", fifo_rd_en);
    end
    repeat (8) step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    mh_err = 0;
    fifo_empty = 4'hF;
    fifo_dout = '0;
    fifo_eop = '0;
    test_reset();
    test_single();
    test_rr_all();
    test_back_pressure();
    test_timeout();
    test_hold_on_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
